// File: rtl/mp_add_sequencer_if.sv
// Operand/result handshake bundle for the multi-precision add/subtract sequencer.
// master: requester + consumer side; slave: the sequencer itself.
interface mp_add_sequencer_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract engine: one 16-bit word adder reused over WORDS
// cycles, least-significant word first, with a registered carry between beats.
module mp_add_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input logic               clk,
    input logic               rst,
    mp_add_sequencer_if.slave bus
);
    localparam int unsigned W    = 16 * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;      // Beff: B already inverted for subtract
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [15:0]     word_a, word_b, word_sum;
    logic            word_cout;
    logic            last_beat;

    // Shared 16-bit word adder fed by the current word slice and the carry register.
    // The subtract flag needs no register of its own: it is folded into Beff and the carry.
    always_comb begin
        word_a                 = a_q[16*idx_q +: 16];
        word_b                 = b_q[16*idx_q +: 16];
        {word_cout, word_sum}  = {1'b0, word_a} + {1'b0, word_b} + {16'd0, carry_q};
        last_beat              = (idx_q == IdxW'(WORDS - 1));
    end

    // Next-state logic: accept in IDLE, one word per RUN cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub | bus.in_cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[16*idx_q +: 16] = word_sum;
                carry_d               = word_cout;
                idx_d                 = idx_q + 1'b1;
                if (last_beat) begin
                    cout_d  = word_cout;
                    // Operands agree in sign but the result does not.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (word_sum[15] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.out_sum   = sum_q;
        bus.out_cout  = cout_q;
        bus.out_ovf   = ovf_q;
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end
endmodule
